// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - Control/datapath bundle between the multi-cycle MIPS controller and its shared-ALU datapath
//
// master: the controller (consumes Instr/Zero/MemReady, issues ALU opcode, selects and write enables)
// slave : the datapath side (supplies IR contents, ALU zero flag and memory ready)
interface mc_ctrl_if;
    logic [31:0] Instr;
    logic        Zero;
    logic        MemReady;
    logic [3:0]  ALUOp;
    logic [1:0]  ALUSrcA;
    logic [2:0]  ALUSrcB;
    logic        PCWrite;
    logic [1:0]  PCSrc;
    logic        IRWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        IorD;
    logic        RegWrite;
    logic [1:0]  RegDst;
    logic [1:0]  MemtoReg;
    logic        Exc;

    modport master (
        input  Instr, Zero, MemReady,
        output ALUOp, ALUSrcA, ALUSrcB, PCWrite, PCSrc, IRWrite,
               MemRead, MemWrite, IorD, RegWrite, RegDst, MemtoReg, Exc
    );

    modport slave (
        output Instr, Zero, MemReady,
        input  ALUOp, ALUSrcA, ALUSrcB, PCWrite, PCSrc, IRWrite,
               MemRead, MemWrite, IorD, RegWrite, RegDst, MemtoReg, Exc
    );
endinterface

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - Multi-cycle MIPS control FSM driving a shared-ALU datapath
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset; returns the FSM to FETCH and clears the trap
//   bus   - mc_ctrl_if.master: Instr/Zero/MemReady in, ALU opcode, operand selects,
//           PC/IR/memory/register write controls and the sticky illegal-instruction trap out
module mc_ctrl #(
    parameter logic [3:0] RESET_STATE_ID = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    mc_ctrl_if.master  bus
);
    // Offsets from the FETCH code keep all encodings distinct for any RESET_STATE_ID.
    typedef enum logic [3:0] {
        FETCH    = RESET_STATE_ID,
        DECODE   = RESET_STATE_ID + 4'd1,
        EXEC_R   = RESET_STATE_ID + 4'd2,
        WB_R     = RESET_STATE_ID + 4'd3,
        EXEC_I   = RESET_STATE_ID + 4'd4,
        WB_I     = RESET_STATE_ID + 4'd5,
        MEM_ADDR = RESET_STATE_ID + 4'd6,
        MEM_RD   = RESET_STATE_ID + 4'd7,
        MEM_WB   = RESET_STATE_ID + 4'd8,
        MEM_WR   = RESET_STATE_ID + 4'd9,
        BRANCH   = RESET_STATE_ID + 4'd10,
        JUMP     = RESET_STATE_ID + 4'd11,
        ILLEGAL  = RESET_STATE_ID + 4'd12
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                           ALU_OR  = 4'b0011, ALU_XOR = 4'b0100, ALU_NOR = 4'b0101,
                           ALU_SLL = 4'b1000, ALU_SRL = 4'b1001, ALU_SRA = 4'b1010,
                           ALU_SLT = 4'b1100, ALU_SLTU = 4'b1101;

    state_t      state_q;
    state_t      decode_d;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        r_ok;
    logic [3:0]  r_alu;
    logic        unused_instr;

    assign op = bus.Instr[31:26];
    assign fn = bus.Instr[5:0];
    // Register/immediate fields are steered by the datapath, not by control.
    assign unused_instr = ^bus.Instr[25:6];

    // R-type funct decode; jr is legal but never reaches EXEC_R.
    always_comb begin
        r_ok  = 1'b1;
        r_alu = ALU_ADD;
        case (fn)
            6'h21:        r_alu = ALU_ADD;
            6'h23:        r_alu = ALU_SUB;
            6'h24:        r_alu = ALU_AND;
            6'h25:        r_alu = ALU_OR;
            6'h26:        r_alu = ALU_XOR;
            6'h27:        r_alu = ALU_NOR;
            6'h00, 6'h04: r_alu = ALU_SLL;
            6'h02, 6'h06: r_alu = ALU_SRL;
            6'h03, 6'h07: r_alu = ALU_SRA;
            6'h2a:        r_alu = ALU_SLT;
            6'h2b:        r_alu = ALU_SLTU;
            6'h08:        r_alu = ALU_ADD;
            default:      r_ok  = 1'b0;
        endcase
    end

    always_comb begin
        decode_d = ILLEGAL;
        case (op)
            6'h00:                                    decode_d = !r_ok ? ILLEGAL : ((fn == 6'h08) ? JUMP : EXEC_R);
            6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: decode_d = EXEC_I;
            6'h23, 6'h2b:                             decode_d = MEM_ADDR;
            6'h04, 6'h05:                             decode_d = BRANCH;
            6'h02, 6'h03:                             decode_d = JUMP;
            default:                                  decode_d = ILLEGAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            case (state_q)
                FETCH:    if (bus.MemReady) state_q <= DECODE;
                DECODE:   state_q <= decode_d;
                EXEC_R:   state_q <= WB_R;
                EXEC_I:   state_q <= WB_I;
                MEM_ADDR: state_q <= (op == 6'h23) ? MEM_RD : MEM_WR;
                MEM_RD:   if (bus.MemReady) state_q <= MEM_WB;
                MEM_WR:   if (bus.MemReady) state_q <= FETCH;
                WB_R, WB_I, MEM_WB, BRANCH, JUMP: state_q <= FETCH;
                ILLEGAL:  state_q <= ILLEGAL;
                default:  state_q <= ILLEGAL;
            endcase
        end
    end

    // Moore outputs; forced quiet while reset is held so an aborted instruction writes nothing.
    always_comb begin
        bus.ALUOp    = ALU_ADD;
        bus.ALUSrcA  = 2'd0;
        bus.ALUSrcB  = 3'd0;
        bus.PCWrite  = 1'b0;
        bus.PCSrc    = 2'd0;
        bus.IRWrite  = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.IorD     = 1'b0;
        bus.RegWrite = 1'b0;
        bus.RegDst   = 2'd0;
        bus.MemtoReg = 2'd0;
        bus.Exc      = 1'b0;
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.ALUSrcA = 2'd2;
                    bus.ALUSrcB = 3'd1;
                    bus.IRWrite = bus.MemReady;
                    bus.PCWrite = bus.MemReady;
                end
                DECODE: begin
                    bus.ALUSrcA = 2'd2;
                    bus.ALUSrcB = 3'd4;
                end
                EXEC_R: begin
                    bus.ALUOp   = r_alu;
                    bus.ALUSrcA = (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) ? 2'd1 : 2'd0;
                end
                WB_R: begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = 2'd1;
                end
                EXEC_I: begin
                    case (op)
                        6'h0a:   begin bus.ALUOp = ALU_SLT;  bus.ALUSrcB = 3'd2; end
                        6'h0b:   begin bus.ALUOp = ALU_SLTU; bus.ALUSrcB = 3'd2; end
                        6'h0c:   begin bus.ALUOp = ALU_AND;  bus.ALUSrcB = 3'd3; end
                        6'h0d:   begin bus.ALUOp = ALU_OR;   bus.ALUSrcB = 3'd3; end
                        6'h0e:   begin bus.ALUOp = ALU_XOR;  bus.ALUSrcB = 3'd3; end
                        // lui: zero-extended imm shifted left by the constant 16
                        6'h0f:   begin bus.ALUOp = ALU_SLL;  bus.ALUSrcB = 3'd3; bus.ALUSrcA = 2'd3; end
                        default: begin bus.ALUOp = ALU_ADD;  bus.ALUSrcB = 3'd2; end
                    endcase
                end
                WB_I: bus.RegWrite = 1'b1;
                MEM_ADDR: bus.ALUSrcB = 3'd2;
                MEM_RD: begin
                    bus.MemRead = 1'b1;
                    bus.IorD    = 1'b1;
                end
                MEM_WB: begin
                    bus.RegWrite = 1'b1;
                    bus.MemtoReg = 2'd1;
                end
                MEM_WR: begin
                    bus.MemWrite = 1'b1;
                    bus.IorD     = 1'b1;
                end
                BRANCH: begin
                    bus.ALUOp   = ALU_SUB;
                    bus.PCSrc   = 2'd1;
                    bus.PCWrite = (op == 6'h04) ? bus.Zero : ~bus.Zero;
                end
                JUMP: begin
                    bus.PCWrite = 1'b1;
                    bus.PCSrc   = (op == 6'h00) ? 2'd3 : 2'd2;
                    if (op == 6'h03) begin
                        bus.RegWrite = 1'b1;
                        bus.RegDst   = 2'd2;
                        bus.MemtoReg = 2'd2;
                    end
                end
                ILLEGAL: bus.Exc = 1'b1;
                default: bus.Exc = 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - Self-checking bench for mc_ctrl against an instruction-level control model
module tb_mc_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mc_ctrl_if bus();
    mc_ctrl #(.RESET_STATE_ID(4'd0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic [3:0] alu_op;
        logic [1:0] src_a;
        logic [2:0] src_b;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       exc;
    } ctl_t;

    typedef enum int {K_R, K_JR, K_I, K_LW, K_SW, K_BR, K_J, K_ILL} kind_t;
    typedef enum int {P_FETCH, P_DEC, P_EX, P_WB, P_ADDR, P_RD, P_LWB, P_WR, P_BR, P_JMP, P_ILL, P_DONE} ph_t;

    ctl_t obs_ctl;
    assign obs_ctl = {bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.PCWrite, bus.PCSrc, bus.IRWrite,
                      bus.MemRead, bus.MemWrite, bus.IorD, bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.Exc};

    int checks = 0;
    int errors = 0;

    logic [5:0] r_fns [15] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h04,
                               6'h02, 6'h06, 6'h03, 6'h07, 6'h2a, 6'h2b, 6'h08};
    logic [5:0] ops [13]   = '{6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
                               6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic kind_t classify(input logic [31:0] ins);
        logic [5:0] op = ins[31:26];
        logic [5:0] fn = ins[5:0];
        if (op == 6'h00) begin
            if (fn == 6'h08) return K_JR;
            foreach (r_fns[i]) if (r_fns[i] == fn) return K_R;
            return K_ILL;
        end
        if (op >= 6'h09 && op <= 6'h0f) return K_I;
        if (op == 6'h23) return K_LW;
        if (op == 6'h2b) return K_SW;
        if (op == 6'h04 || op == 6'h05) return K_BR;
        if (op == 6'h02 || op == 6'h03) return K_J;
        return K_ILL;
    endfunction

    function automatic int base_lat(input kind_t k);
        case (k)
            K_LW:              return 5;
            K_R, K_I, K_SW:    return 4;
            default:           return 3;
        endcase
    endfunction

    function automatic logic [3:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'h21: return 4'b0000;  6'h23: return 4'b0001;
            6'h24: return 4'b0010;  6'h25: return 4'b0011;
            6'h26: return 4'b0100;  6'h27: return 4'b0101;
            6'h00, 6'h04: return 4'b1000;
            6'h02, 6'h06: return 4'b1001;
            6'h03, 6'h07: return 4'b1010;
            6'h2a: return 4'b1100;  6'h2b: return 4'b1101;
            default: return 4'bxxxx;
        endcase
    endfunction

    function automatic ctl_t exp_ctl(input ph_t p, input logic [31:0] ins, input logic mr, input logic z);
        ctl_t c = '0;
        logic [5:0] op = ins[31:26];
        logic [5:0] fn = ins[5:0];
        case (p)
            P_FETCH: begin c.mem_read = 1; c.src_a = 2; c.src_b = 1; c.ir_write = mr; c.pc_write = mr; end
            P_DEC:   begin c.src_a = 2; c.src_b = 4; end
            P_EX: if (op == 6'h00) begin
                c.alu_op = r_alu(fn);
                c.src_a  = (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) ? 2'd1 : 2'd0;
            end else begin
                case (op)
                    6'h09: begin c.alu_op = 4'b0000; c.src_b = 2; end
                    6'h0a: begin c.alu_op = 4'b1100; c.src_b = 2; end
                    6'h0b: begin c.alu_op = 4'b1101; c.src_b = 2; end
                    6'h0c: begin c.alu_op = 4'b0010; c.src_b = 3; end
                    6'h0d: begin c.alu_op = 4'b0011; c.src_b = 3; end
                    6'h0e: begin c.alu_op = 4'b0100; c.src_b = 3; end
                    default: begin c.alu_op = 4'b1000; c.src_b = 3; c.src_a = 3; end
                endcase
            end
            P_WB:   begin c.reg_write = 1; c.reg_dst = (op == 6'h00) ? 2'd1 : 2'd0; end
            P_ADDR: c.src_b = 2;
            P_RD:   begin c.mem_read = 1; c.iord = 1; end
            P_LWB:  begin c.reg_write = 1; c.mem_to_reg = 1; end
            P_WR:   begin c.mem_write = 1; c.iord = 1; end
            P_BR:   begin c.alu_op = 4'b0001; c.pc_src = 1; c.pc_write = (op == 6'h04) ? z : ~z; end
            P_JMP: begin
                c.pc_write = 1;
                c.pc_src = (op == 6'h00) ? 2'd3 : 2'd2;
                if (op == 6'h03) begin c.reg_write = 1; c.reg_dst = 2; c.mem_to_reg = 2; end
            end
            P_ILL:  c.exc = 1;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic ph_t next_ph(input ph_t p, input kind_t k, input logic mr);
        case (p)
            P_FETCH: return mr ? P_DEC : P_FETCH;
            P_DEC: case (k)
                K_R, K_I:    return P_EX;
                K_JR, K_J:   return P_JMP;
                K_LW, K_SW:  return P_ADDR;
                K_BR:        return P_BR;
                default:     return P_ILL;
            endcase
            P_EX:   return P_WB;
            P_ADDR: return (k == K_LW) ? P_RD : P_WR;
            P_RD:   return mr ? P_LWB : P_RD;
            P_WR:   return mr ? P_DONE : P_WR;
            P_ILL:  return P_ILL;
            default: return P_DONE;
        endcase
    endfunction

    // Runs one instruction from its FETCH cycle, checking every cycle's outputs.
    // Instr carries junk during FETCH: the controller must not look at it there.
    task automatic run_instr(input string name, input logic [31:0] ins, input int stall_pct,
                             input int rd_stalls, input int zf, input int budget,
                             input bit lat_chk, output int cycles);
        ph_t p = P_FETCH;
        kind_t k = classify(ins);
        int stalls = 0;
        int rd_cnt = 0;
        logic mr, z;
        cycles = 0;
        while (p != P_DONE && cycles < budget) begin
            @(negedge clk);
            mr = ($urandom_range(99) >= stall_pct);
            if (p == P_RD && rd_cnt < rd_stalls) begin mr = 1'b0; rd_cnt++; end
            z = (zf < 0) ? 1'($urandom_range(1)) : zf[0];
            bus.MemReady = mr;
            bus.Zero     = z;
            bus.Instr    = (p == P_FETCH) ? $urandom() : ins;
            #1;
            chk($sformatf("%s/%s/c%0d", name, p.name(), cycles), obs_ctl, exp_ctl(p, ins, mr, z));
            if (!mr && (p == P_FETCH || p == P_RD || p == P_WR)) stalls++;
            p = next_ph(p, k, mr);
            cycles++;
        end
        if (lat_chk) chk({name, "/latency"}, cycles, base_lat(k) + stalls);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst_n = 1'b0;
        bus.MemReady = 1'b1;
        #1 chk({name, "/in_reset"}, obs_ctl, 32'd0);
        @(negedge clk);
        #1 chk({name, "/in_reset2"}, obs_ctl, 32'd0);
        rst_n = 1'b1;
        bus.MemReady = 1'b0;
        #1 chk({name, "/fetch_after"}, obs_ctl, exp_ctl(P_FETCH, 32'd0, 1'b0, 1'b0));
    endtask

    initial begin
        int cyc;
        logic [31:0] ins;
        rst_n = 1'b0;
        bus.Instr = '0;
        bus.Zero = 1'b0;
        bus.MemReady = 1'b0;
        do_reset("init");

        ins = $urandom(); ins[31:26] = 6'h00; ins[5:0] = 6'h21;
        run_instr("addu", ins, 0, 0, -1, 20, 1, cyc);
        chk("addu_4cyc", cyc, 4);

        run_instr("lui", 32'h3C011234, 0, 0, -1, 20, 1, cyc);
        chk("lui_4cyc", cyc, 4);
        run_instr("sra", 32'h00021083, 0, 0, -1, 20, 1, cyc);

        ins = $urandom(); ins[31:26] = 6'h23;
        run_instr("lw_stall", ins, 0, 2, -1, 20, 1, cyc);
        chk("lw_7cyc", cyc, 7);

        ins = $urandom(); ins[31:26] = 6'h2b;
        run_instr("sw", ins, 0, 0, -1, 20, 1, cyc);
        chk("sw_4cyc", cyc, 4);

        ins = $urandom(); ins[31:26] = 6'h04;
        run_instr("beq_z1", ins, 0, 0, 1, 20, 1, cyc);
        chk("beq_3cyc", cyc, 3);
        ins[31:26] = 6'h05;
        run_instr("bne_z1", ins, 0, 0, 1, 20, 1, cyc);

        ins = $urandom(); ins[31:26] = 6'h03;
        run_instr("jal", ins, 0, 0, -1, 20, 1, cyc);
        chk("jal_3cyc", cyc, 3);

        // Abort an R-type in EXEC_R: reset must silence WB_R.
        ins = $urandom(); ins[31:26] = 6'h00; ins[5:0] = 6'h25;
        run_instr("abort", ins, 0, 0, -1, 3, 0, cyc);
        do_reset("abort_rst");

        for (int n = 0; n < 80; n++) begin
            ins = $urandom();
            if ($urandom_range(3) == 0) begin
                ins[31:26] = 6'h00;
                ins[5:0] = r_fns[$urandom_range(14)];
            end else begin
                ins[31:26] = ops[$urandom_range(12)];
            end
            run_instr($sformatf("rnd%0d", n), ins, 25, 0, -1, 60, 1, cyc);
        end

        ins = $urandom(); ins[31:26] = 6'h00; ins[5:0] = 6'h01;
        run_instr("bad_funct", ins, 20, 0, -1, 8, 0, cyc);
        chk("bad_funct_exc", bus.Exc, 1);
        do_reset("bad_funct_rst");

        ins = $urandom(); ins[31:26] = 6'h3F;
        run_instr("op3f", ins, 0, 0, -1, 25, 0, cyc);
        chk("op3f_exc_held", bus.Exc, 1);
        do_reset("op3f_rst");
        chk("op3f_exc_cleared", bus.Exc, 0);

        ins = $urandom(); ins[31:26] = 6'h00; ins[5:0] = 6'h08;
        run_instr("jr", ins, 0, 0, -1, 20, 1, cyc);
        chk("jr_3cyc", cyc, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle MIPS control FSM; the issuing end of the ALU operand/opcode interface.
- Decodes the instruction register and drives per-cycle ALU opcode, operand selects, and register/memory/PC write enables for the shared-ALU datapath.
- Waits on a memory ready handshake; traps unsupported encodings.

Parameters:
- RESET_STATE_ID, 4'd0, encoding of FETCH, also the reset state.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- Instr  input  32  IR contents; valid from DECODE onward.
- Zero  input  1  datapath flag, ALU result == 0.
- MemReady  input  1  memory completes the current read/write this cycle.
- ALUOp  output  4  opcode to ALU: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 nor, 1000 sll, 1001 srl, 1010 sra, 1100 slt, 1101 sltu; shift amount is A[4:0], shifted value is B.
- ALUSrcA  output  2  0 rs, 1 zero-extended Instr[10:6], 2 PC, 3 constant 16.
- ALUSrcB  output  3  0 rt, 1 constant 4, 2 sign-ext imm, 3 zero-ext imm, 4 sign-ext imm<<2.
- PCWrite  output  1  load PC.
- PCSrc  output  2  0 ALU result, 1 ALUOut register, 2 {PC[31:28],Instr[25:0],2'b00}, 3 rs.
- IRWrite  output  1  load IR from memory data.
- MemRead  output  1  memory read request; IorD selects address.
- MemWrite  output  1  memory write request.
- IorD  output  1  0 PC, 1 ALUOut.
- RegWrite  output  1  register file write.
- RegDst  output  2  0 rt, 1 rd, 2 register 31.
- MemtoReg  output  2  0 ALUOut, 1 MDR, 2 PC (link).
- Exc  output  1  illegal instruction trap, sticky.

Behaviour:
- All outputs are combinational (Moore) from the state register and Instr.
- Every output not listed for a state is 0.
- rst_n low, asynchronous: state <- FETCH, Exc <- 0. Reset mid-instruction aborts it with no further writes.
- FETCH: MemRead=1, IorD=0, ALUSrcA=2, ALUSrcB=1, ALUOp=add.
  - IRWrite=PCWrite=MemReady, PCSrc=0.
  - Stays in FETCH until MemReady, then goes to DECODE.
- DECODE: ALUSrcA=2, ALUSrcB=4, ALUOp=add (branch target into ALUOut). Next state:
  - R-type with supported funct -> EXEC_R; funct 08 (jr) -> JUMP.
  - addiu, andi, ori, xori, lui, slti, sltiu -> EXEC_I.
  - lw/sw -> MEM_ADDR.
  - beq/bne -> BRANCH.
  - j/jal -> JUMP.
  - Anything else -> ILLEGAL.
- EXEC_R: ALUSrcA=1 for sll/srl/sra, otherwise 0; ALUSrcB=0. ALUOp by funct:
  - 21 add, 23 sub, 24 and, 25 or, 26 xor, 27 nor.
  - 00/04 sll, 02/06 srl, 03/07 sra.
  - 2a slt, 2b sltu.
  - Next state: WB_R.
- WB_R: RegWrite=1, RegDst=1, MemtoReg=0. Next state: FETCH.
- EXEC_I: ALUSrcA=0, except lui uses ALUSrcA=3 with ALUOp=sll and ALUSrcB=3.
  - addiu: add, SrcB=2. andi/ori/xori: and/or/xor, SrcB=3. slti/sltiu: slt/sltu, SrcB=2.
  - Next state: WB_I.
- WB_I: RegWrite=1, RegDst=0, MemtoReg=0. Next state: FETCH.
- MEM_ADDR: ALUSrcA=0, ALUSrcB=2, ALUOp=add. Next state: MEM_RD for lw, MEM_WR for sw.
- MEM_RD: MemRead=1, IorD=1. Holds until MemReady, then goes to MEM_WB.
- MEM_WB: RegWrite=1, RegDst=0, MemtoReg=1. Next state: FETCH.
- MEM_WR: MemWrite=1, IorD=1. Holds until MemReady, then goes to FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=0, ALUOp=sub, PCSrc=1.
  - PCWrite=Zero for beq, ~Zero for bne.
  - Next state: FETCH.
- JUMP: PCWrite=1. Next state: FETCH.
  - j: PCSrc=2.
  - jal: PCSrc=2, plus RegWrite=1, RegDst=2, MemtoReg=2 (PC already +4).
  - jr: PCSrc=3.
- ILLEGAL: Exc=1, all enables 0, no exit except reset.
- Latency with MemReady constantly 1:
  - R-type / I-ALU: 4 cycles. lw: 5. sw: 4.
  - beq/bne: 3. j/jal/jr: 3.
  - Each MemReady-low cycle in FETCH/MEM_RD/MEM_WR adds 1 cycle.
- Sensitivity: only Instr[31:26], [5:0] and Zero affect control. Instr changing outside DECODE..WB has no effect, because IR is loaded only in FETCH.

Test Plan:
- Reset low mid-EXEC_R, then release: outputs all 0 during reset; first cycle after release is FETCH with MemRead=1, ALUOp=0000, ALUSrcB=1.
- addu (funct 21), MemReady=1: exactly 4 cycles; EXEC_R drives ALUOp=0000/SrcA=0/SrcB=0; WB_R drives RegWrite=1, RegDst=1.
- lui 0x3C011234: EXEC_I drives ALUSrcA=3, ALUSrcB=3, ALUOp=1000; WB_I drives RegWrite=1, RegDst=0; sra 0x00021083 drives ALUSrcA=1, ALUOp=1010.
- lw with MemReady low for 2 cycles in MEM_RD: 7 cycles total; MemRead/IorD held high throughout; a single RegWrite with MemtoReg=1.
- beq with Zero=1 -> PCWrite=1, PCSrc=1 in BRANCH; bne with Zero=1 -> PCWrite=0; both return to FETCH next cycle.
- jal -> PCWrite=1, PCSrc=2, RegWrite=1, RegDst=2, MemtoReg=2; opcode 0x3F -> Exc=1 held indefinitely with all enables 0, cleared only by rst_n low.
